bank_sched: RTL and testbench
=============================

BANK_SCHED -- requirements
Module: bank_sched

Interface
REQ-001 SHALL have parameter NR, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter NB, default 32, number of banks; A = $clog2(NB) is the bank index width.
REQ-003 SHALL have parameter LW, default 4, burst-length field width.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req  input  NR  per-requester request, level; held until the requester's last beat.
REQ-007 req_bank  input  NR*A  bank index for requester i at bits [i*A +: A].
REQ-008 req_len  input  NR*LW  beats minus one for requester i at bits [i*LW +: LW].
REQ-009 gnt  output  NR  one-hot grant, registered.
REQ-010 csel  output  NB  one-hot bank chip-select of the active burst, registered.
REQ-011 beat  output  1  high on every cycle of an active burst.
REQ-012 last  output  1  high on the final beat of a burst.
REQ-013 err  output  1  one-cycle pulse on the first beat when the granted bank index is >= NB.
REQ-014 busy  output  1  equals beat; high while a burst is in progress.

Function
REQ-015 SHALL implement a two-state FSM: IDLE and BURST.
REQ-016 IDLE: if any req bit is high, SHALL select a winner by round-robin; otherwise SHALL remain in IDLE.
- Search starts at pointer ptr and wraps modulo NR.
REQ-017 On selection, SHALL latch the winner index, its req_bank and its req_len into cnt, and SHALL enter BURST the next cycle.
- Latency: req high in cycle N (IDLE) gives gnt/beat high in cycle N+1.
REQ-018 On selection, SHALL set ptr to (winner+1) mod NR, so the last-served requester has lowest priority.
REQ-019 BURST, every cycle:
- gnt = onehot(winner), beat = 1.
- csel = onehot(latched bank), or all-zero if bank >= NB.
- cnt decrements by 1.
REQ-020 last SHALL be high when cnt == 0; a burst lasts req_len+1 cycles (1..2^LW).
REQ-021 In the last-beat cycle, SHALL arbitrate as in IDLE.
- If a request wins, its burst SHALL begin the next cycle (back-to-back, no gap).
- Otherwise the FSM SHALL return to IDLE, with gnt, csel, beat and last all zero.
REQ-022 SHALL sample the winner's req_bank and req_len only at selection; later changes to them SHALL NOT affect the active burst.
REQ-023 A burst SHALL run to completion even if the winner's req deasserts mid-burst (no abort).
REQ-024 Requests in mid-burst cycles other than the last beat SHALL be ignored for arbitration and SHALL NOT move ptr.
REQ-025 SHALL keep gnt and csel each at most one bit high in every cycle.
REQ-026 err SHALL pulse only on the first beat of an out-of-range burst; the burst still counts its full length with csel all zero.
REQ-027 A single continuous requester SHALL be re-granted back-to-back when no other req is high.

Reset
REQ-028 While rst is high, SHALL force:
- state = IDLE, ptr = 0, cnt = 0;
- gnt, csel, beat, last, err, busy = 0.
REQ-029 Reset asserted mid-burst SHALL clear all outputs asynchronously, with no completion of the burst.
REQ-030 After rst deasserts, the first arbitration SHALL start the search from requester 0.

Verification
REQ-031 Single request, NB=32: req=0001, bank0=5, len0=2 -> gnt=0001 and csel=1<<5 for 3 cycles starting 1 cycle after req; last on the 3rd; then idle.
REQ-032 Contention: req=1111 held, all len=0 -> grants 0,1,2,3,0,... on consecutive cycles, each last=1, no idle gap.
REQ-033 Back-to-back with priority:
- req0 (len=3) and req2 (len=1) asserted together -> req0 served 4 cycles, then req2 2 cycles with no gap.
- If req0 is still high, it is served next.
REQ-034 Out of range, NB=20: bank=25, len=1 -> 2 beats with csel=0, err high on the first beat only.
REQ-035 Mid-burst reset: rst pulsed on the 2nd beat of a len=7 burst -> all outputs 0 immediately.
- After release with req=0100, grant goes to requester 2 one cycle after the first IDLE cycle.
REQ-036 Mid-burst input change: change req_bank/req_len and drop req during a burst -> csel and burst length unchanged until last.

Source files
------------

// File: rtl/bank_sched.sv
// -----------------------------------------------------------------------------
// bank_sched
// Round-robin burst scheduler. Up to NR requesters each ask for a burst to one
// of NB banks. One winner at a time is granted; its bank index and burst length
// are captured at selection and the burst runs to completion, driving a one-hot
// bank chip-select on every beat. Arbitration happens in IDLE and again on the
// last beat of a burst, so a waiting requester follows with no idle gap.
//
// Handshake: req[i] is a level request that the requester holds until the
// cycle in which it sees gnt[i] together with last. A request sampled high at
// a rising edge in IDLE (or on a last beat) becomes gnt/beat one cycle later.
// The winner's req_bank/req_len are sampled only at that selecting edge.
//
// Ports
//   clk       sole clock, rising edge
//   rst       asynchronous, active-high reset
//   req       per-requester request level              [NR]
//   req_bank  bank index of requester i at [i*A +: A]  [NR*A]
//   req_len   beats-minus-one of requester i           [NR*LW]
//   gnt       one-hot grant of the active burst        [NR]   (registered)
//   csel      one-hot bank select, 0 if out of range   [NB]   (registered)
//   beat      high on every beat of a burst
//   last      high on the final beat
//   err       pulse on the first beat of an out-of-range burst
//   busy      same as beat
// -----------------------------------------------------------------------------
module bank_sched #(
    parameter int NR = 4,
    parameter int NB = 32,
    parameter int LW = 4,
    localparam int A  = $clog2(NB),
    localparam int PW = $clog2(NR)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NR-1:0]    req,
    input  logic [NR*A-1:0]  req_bank,
    input  logic [NR*LW-1:0] req_len,
    output logic [NR-1:0]    gnt,
    output logic [NB-1:0]    csel,
    output logic             beat,
    output logic             last,
    output logic             err,
    output logic             busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t        state;
    logic [PW-1:0] ptr;
    logic [LW-1:0] cnt;

    logic          win_found;
    logic [PW-1:0] win_idx;
    logic [A-1:0]  win_bank;
    logic [LW-1:0] win_len;
    logic          win_in_range;
    logic [PW-1:0] ptr_nxt;
    logic          start;
    int            scan;

    // Round-robin search beginning at ptr and wrapping modulo NR.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan      = 0;
        for (int k = 0; k < NR; k++) begin
            scan = int'(ptr) + k;
            if (scan >= NR) begin
                scan = scan - NR;
            end
            if (!win_found && req[PW'(scan)]) begin
                win_found = 1'b1;
                win_idx   = PW'(scan);
            end
        end
    end

    assign win_bank = req_bank[win_idx*A +: A];
    assign win_len  = req_len[win_idx*LW +: LW];

    // A+1 bits always hold NB because NB <= 2**A.
    assign win_in_range = ({1'b0, win_bank} < (A+1)'(NB));

    // The served requester drops to lowest priority.
    assign ptr_nxt = (win_idx == PW'(NR-1)) ? '0 : win_idx + 1'b1;

    // Arbitration is live in IDLE and on the last beat (cnt == 0) of a burst;
    // mid-burst requests are ignored and leave ptr untouched.
    assign start = win_found && ((state == IDLE) || (cnt == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            cnt   <= '0;
            gnt   <= '0;
            csel  <= '0;
            beat  <= 1'b0;
            last  <= 1'b0;
            err   <= 1'b0;
        end else if (start) begin
            state <= BURST;
            ptr   <= ptr_nxt;
            cnt   <= win_len;
            gnt   <= NR'(1) << win_idx;
            csel  <= win_in_range ? (NB'(1) << win_bank) : '0;
            beat  <= 1'b1;
            last  <= (win_len == '0);
            err   <= !win_in_range;
        end else if ((state == BURST) && (cnt != '0)) begin
            // gnt and csel hold the captured winner and bank for the burst.
            cnt  <= cnt - 1'b1;
            last <= (cnt == LW'(1));
            err  <= 1'b0;
        end else begin
            state <= IDLE;
            cnt   <= '0;
            gnt   <= '0;
            csel  <= '0;
            beat  <= 1'b0;
            last  <= 1'b0;
            err   <= 1'b0;
        end
    end

    assign busy = beat;

endmodule

// File: tb/tb_bank_sched.sv
// -----------------------------------------------------------------------------
// tb_bank_sched
// Drives two schedulers (NB=32 and NB=20) from the same inputs and compares
// each against a transaction-level reference that tracks "beats remaining" for
// the active burst plus a round-robin pointer. Directed scenarios add fixed
// expectations on top of the reference.
// -----------------------------------------------------------------------------
module tb_bank_sched;

    localparam int NR = 4;
    localparam int LW = 4;
    localparam int A  = 5;

    logic             clk;
    logic             rst;
    logic [NR-1:0]    req;
    logic [NR*A-1:0]  req_bank;
    logic [NR*LW-1:0] req_len;

    logic [NR-1:0] gnt_a;
    logic [31:0]   csel_a;
    logic          beat_a, last_a, err_a, busy_a;
    logic [NR-1:0] gnt_b;
    logic [19:0]   csel_b;
    logic          beat_b, last_b, err_b, busy_b;

    bank_sched #(.NR(NR), .NB(32), .LW(LW)) dut32 (
        .clk(clk), .rst(rst), .req(req), .req_bank(req_bank), .req_len(req_len),
        .gnt(gnt_a), .csel(csel_a), .beat(beat_a), .last(last_a), .err(err_a),
        .busy(busy_a)
    );

    bank_sched #(.NR(NR), .NB(20), .LW(LW)) dut20 (
        .clk(clk), .rst(rst), .req(req), .req_bank(req_bank), .req_len(req_len),
        .gnt(gnt_b), .csel(csel_b), .beat(beat_b), .last(last_b), .err(err_b),
        .busy(busy_b)
    );

    wire [39:0] obs32 = {gnt_a, csel_a, beat_a, last_a, err_a, busy_a};
    wire [27:0] obs20 = {gnt_b, csel_b, beat_b, last_b, err_b, busy_b};

    int total = 0;
    int bad   = 0;

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int         rem   = 0;   // beats still to be shown, including the current one
    int         ptr_m = 0;
    int         cur_w = 0;
    logic [4:0] cur_bank = '0;
    bit         first = 0;
    logic [39:0] exp32 = '0;
    logic [27:0] exp20 = '0;
    logic [3:0]  e_gnt = '0;
    logic        e_last = 1'b0;

    task automatic model_step();
        logic        eb;
        logic [31:0] c32;
        logic [19:0] c20;
        if (rst) begin
            rem   = 0;
            ptr_m = 0;
            first = 0;
        end else if (rem <= 1 && req != '0) begin
            for (int k = 0; k < NR; k++) begin
                int i;
                i = (ptr_m + k) % NR;
                if (req[i]) begin
                    cur_w = i;
                    break;
                end
            end
            ptr_m    = (cur_w + 1) % NR;
            cur_bank = req_bank[cur_w*A +: A];
            rem      = int'(req_len[cur_w*LW +: LW]) + 1;
            first    = 1;
        end else begin
            if (rem > 0) rem--;
            first = 0;
        end
        eb     = (rem > 0);
        e_last = (rem == 1);
        e_gnt  = eb ? 4'(1 << cur_w) : 4'b0;
        c32    = (eb && cur_bank < 32) ? (32'(1) << cur_bank) : 32'b0;
        c20    = (eb && cur_bank < 20) ? (20'(1) << cur_bank) : 20'b0;
        exp32  = {e_gnt, c32, eb, e_last, eb && first && (cur_bank >= 32), eb};
        exp20  = {e_gnt, c20, eb, e_last, eb && first && (cur_bank >= 20), eb};
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        req = '0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        req = '0;
        step();
        step();
        total++;
        if (obs32 !== 40'b0) begin
            bad++; $display("FAIL reset nb32: got %h want 0", obs32);
        end
        total++;
        if (obs20 !== 28'b0) begin
            bad++; $display("FAIL reset nb20: got %h want 0", obs20);
        end
        rst = 1'b0;
        step();
        total++;
        if (obs32 !== exp32) begin
            bad++; $display("FAIL reset_idle nb32: got %h want %h", obs32, exp32);
        end
        total++;
        if (obs20 !== exp20) begin
            bad++; $display("FAIL reset_idle nb20: got %h want %h", obs20, exp20);
        end
    endtask

    task automatic test_single();
        logic [39:0] d32;
        do_reset();
        req_bank = '0;
        req_len  = '0;
        req_bank[0 +: A]  = 5'd5;
        req_len[0 +: LW]  = 4'd2;
        req = 4'b0001;
        for (int c = 0; c < 6; c++) begin
            step();
            d32 = (c < 3) ? {4'b0001, 32'h20, 1'b1, (c == 2), 1'b0, 1'b1} : 40'b0;
            total++;
            if (obs32 !== d32) begin
                bad++; $display("FAIL single_dir c%0d: got %h want %h", c, obs32, d32);
            end
            total++;
            if (obs32 !== exp32) begin
                bad++; $display("FAIL single nb32 c%0d: got %h want %h", c, obs32, exp32);
            end
            total++;
            if (obs20 !== exp20) begin
                bad++; $display("FAIL single nb20 c%0d: got %h want %h", c, obs20, exp20);
            end
            if (c == 2) req = '0;
        end
    endtask

    task automatic test_contention();
        do_reset();
        req_len = '0;
        req_bank = {5'd3, 5'd2, 5'd1, 5'd0};
        req = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            logic [3:0] g;
            step();
            g = 4'(1 << (c % 4));
            total++;
            if (gnt_a !== g || last_a !== 1'b1 || beat_a !== 1'b1) begin
                bad++; $display("FAIL contention_dir c%0d: got gnt=%b last=%b want gnt=%b last=1", c, gnt_a, last_a, g);
            end
            total++;
            if (obs32 !== exp32) begin
                bad++; $display("FAIL contention nb32 c%0d: got %h want %h", c, obs32, exp32);
            end
            total++;
            if (obs20 !== exp20) begin
                bad++; $display("FAIL contention nb20 c%0d: got %h want %h", c, obs20, exp20);
            end
        end
        req = '0;
        step();
        total++;
        if (obs32 !== 40'b0) begin
            bad++; $display("FAIL contention_idle: got %h want 0", obs32);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_g [10];
        exp_g = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd4, 4'd4, 4'd1, 4'd1, 4'd1, 4'd1};
        do_reset();
        req_bank = '0;
        req_len  = '0;
        req_bank[0 +: A]    = 5'd3;
        req_len[0 +: LW]    = 4'd3;
        req_bank[2*A +: A]  = 5'd10;
        req_len[2*LW +: LW] = 4'd1;
        req = 4'b0101;
        for (int c = 0; c < 10; c++) begin
            step();
            total++;
            if (gnt_a !== exp_g[c] || beat_a !== 1'b1) begin
                bad++; $display("FAIL b2b_dir c%0d: got gnt=%b beat=%b want gnt=%b beat=1", c, gnt_a, beat_a, exp_g[c]);
            end
            total++;
            if (obs32 !== exp32) begin
                bad++; $display("FAIL b2b nb32 c%0d: got %h want %h", c, obs32, exp32);
            end
            total++;
            if (obs20 !== exp20) begin
                bad++; $display("FAIL b2b nb20 c%0d: got %h want %h", c, obs20, exp20);
            end
            if (c == 5) req[2] = 1'b0;
        end
        req = '0;
        step();
        total++;
        if (obs32 !== 40'b0) begin
            bad++; $display("FAIL b2b_idle: got %h want 0", obs32);
        end
    endtask

    task automatic test_out_of_range();
        logic [27:0] d20;
        logic [39:0] d32;
        req_bank[1*A +: A]  = 5'd25;
        req_len[1*LW +: LW] = 4'd1;
        req = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            step();
            d20 = (c < 2) ? {4'b0010, 20'b0, 1'b1, (c == 1), (c == 0), 1'b1} : 28'b0;
            d32 = (c < 2) ? {4'b0010, 32'h0200_0000, 1'b1, (c == 1), 1'b0, 1'b1} : 40'b0;
            total++;
            if (obs20 !== d20) begin
                bad++; $display("FAIL oor_dir nb20 c%0d: got %h want %h", c, obs20, d20);
            end
            total++;
            if (obs32 !== d32) begin
                bad++; $display("FAIL oor_dir nb32 c%0d: got %h want %h", c, obs32, d32);
            end
            total++;
            if (obs20 !== exp20) begin
                bad++; $display("FAIL oor nb20 c%0d: got %h want %h", c, obs20, exp20);
            end
            if (c == 1) req = '0;
        end
    endtask

    task automatic test_mid_reset();
        req_bank[2*A +: A]  = 5'd12;
        req_len[2*LW +: LW] = 4'd7;
        req = 4'b0100;
        for (int c = 0; c < 2; c++) begin
            step();
            total++;
            if (obs32 !== exp32) begin
                bad++; $display("FAIL midrst_pre nb32 c%0d: got %h want %h", c, obs32, exp32);
            end
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (obs32 !== 40'b0 || obs20 !== 28'b0) begin
            bad++; $display("FAIL midrst_async: got %h/%h want 0/0", obs32, obs20);
        end
        model_step();
        step();
        total++;
        if (obs32 !== exp32) begin
            bad++; $display("FAIL midrst_hold nb32: got %h want %h", obs32, exp32);
        end
        rst = 1'b0;
        step();
        total++;
        if (gnt_a !== 4'b0100 || beat_a !== 1'b1 || csel_a !== 32'h0000_1000) begin
            bad++; $display("FAIL midrst_regrant: got gnt=%b csel=%h want gnt=0100 csel=00001000", gnt_a, csel_a);
        end
        for (int c = 0; c < 12; c++) begin
            if (e_last) req = '0;
            step();
            total++;
            if (obs32 !== exp32) begin
                bad++; $display("FAIL midrst_drain nb32 c%0d: got %h want %h", c, obs32, exp32);
            end
            total++;
            if (obs20 !== exp20) begin
                bad++; $display("FAIL midrst_drain nb20 c%0d: got %h want %h", c, obs20, exp20);
            end
        end
    endtask

    task automatic test_mid_change();
        logic [39:0] d32;
        req_bank[3*A +: A]  = 5'd7;
        req_len[3*LW +: LW] = 4'd4;
        req = 4'b1000;
        for (int c = 0; c < 6; c++) begin
            step();
            if (c == 0) begin
                req_bank[3*A +: A]  = 5'd9;
                req_len[3*LW +: LW] = 4'd0;
                req = '0;
            end
            d32 = (c < 5) ? {4'b1000, 32'h80, 1'b1, (c == 4), 1'b0, 1'b1} : 40'b0;
            total++;
            if (obs32 !== d32) begin
                bad++; $display("FAIL midchg_dir c%0d: got %h want %h", c, obs32, d32);
            end
            total++;
            if (obs20 !== exp20) begin
                bad++; $display("FAIL midchg nb20 c%0d: got %h want %h", c, obs20, exp20);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (!req[i] && $urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                    req_bank[i*A +: A]  = 5'($urandom_range(0, 31));
                    req_len[i*LW +: LW] = 4'($urandom_range(0, 3));
                end
            end
            step();
            total++;
            if (obs32 !== exp32) begin
                bad++; $display("FAIL random nb32 c%0d: got %h want %h", c, obs32, exp32);
            end
            total++;
            if (obs20 !== exp20) begin
                bad++; $display("FAIL random nb20 c%0d: got %h want %h", c, obs20, exp20);
            end
            for (int i = 0; i < NR; i++) begin
                if (e_gnt[i] && e_last) begin
                    if ($urandom_range(0, 1) == 0) begin
                        req[i] = 1'b0;
                    end else begin
                        req_bank[i*A +: A]  = 5'($urandom_range(0, 31));
                        req_len[i*LW +: LW] = 4'($urandom_range(0, 3));
                    end
                end
            end
        end
        req = '0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst      = 1'b1;
        req      = '0;
        req_bank = '0;
        req_len  = '0;
        test_reset();
        test_single();
        test_contention();
        test_back_to_back();
        test_out_of_range();
        test_mid_reset();
        test_mid_change();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
